// File: rtl/pe_result_drain.sv
// Result drain for the dual-product PE: rounds, shifts and saturates both accumulators,
// buffers the pairs in a small FIFO and serializes them as A then B on a valid/ready stream.
module pe_result_drain #(
  parameter int  ACC_WIDTH = 22,
  parameter int  OUT_WIDTH = 8,
  parameter int  SHIFT     = 7,
  parameter int  DEPTH     = 4,
  localparam int LEVEL_W   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [ACC_WIDTH-1:0] resulta,
  input  logic [ACC_WIDTH-1:0] resultb,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  input  logic                 ovf_clr,
  output logic                 overflow,
  output logic                 sat_seen,
  output logic [LEVEL_W-1:0]   level
);

  localparam int RW = ACC_WIDTH + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic signed [RW-1:0] HALF  = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [RW-1:0] MAX_S = RW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] MIN_S = ~MAX_S;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] qa;
    logic [OUT_WIDTH-1:0] qb;
  } pair_t;

  typedef enum logic {SEL_A, SEL_B} sel_e;

  // Returns {clamped, word}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [RW-1:0] s);
    if (s > MAX_S) return {1'b1, MAX_S[OUT_WIDTH-1:0]};
    if (s < MIN_S) return {1'b1, MIN_S[OUT_WIDTH-1:0]};
    return {1'b0, s[OUT_WIDTH-1:0]};
  endfunction

  logic signed [RW-1:0] round_a, round_b, s1_a, s1_b;
  logic                 s1_valid;
  pair_t                mem [DEPTH];
  pair_t                head, push_pair;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  sel_e                 state, state_nxt;
  logic                 full, handshake, pop, push, drop, sat_a, sat_b;

  // One guard bit keeps the half-LSB add from wrapping.
  always_comb begin
    round_a = $signed({resulta[ACC_WIDTH-1], resulta}) + HALF;
    round_b = $signed({resultb[ACC_WIDTH-1], resultb}) + HALF;
  end

  // NOTE: state registers use non-blocking assignments and the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= round_a >>> SHIFT;
        s1_b <= round_b >>> SHIFT;
      end
    end
  end

  // A full FIFO still accepts a push when the head pair completes on the same edge.
  always_comb begin
    {sat_a, push_pair.qa} = saturate(s1_a);
    {sat_b, push_pair.qb} = saturate(s1_b);
    head      = mem[rd_ptr];
    full      = (level == LEVEL_W'(DEPTH));
    out_valid = (level != '0);
    handshake = out_valid && out_ready;
    pop       = handshake && (state == SEL_B);
    push      = s1_valid && (!full || pop);
    drop      = s1_valid && full && !pop;
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = (state == SEL_B) ? head.qb : head.qa;
      out_last = (state == SEL_B);
    end
    if (handshake) state_nxt = (state == SEL_A) ? SEL_B : SEL_A;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEL_A;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      sat_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      // Set events take priority over the clear.
      overflow <= drop || (overflow && !ovf_clr);
      sat_seen <= (s1_valid && (sat_a || sat_b)) || (sat_seen && !ovf_clr);
    end
  end

  // NOTE: the storage array is not reset; out_valid masks stale entries, so only pointers and level need it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_pair;
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: queue-based reference model checked every cycle, plus
// directed vectors with literal expected words.
module tb_pe_result_drain;

  localparam int ACC_WIDTH = 22;
  localparam int OUT_WIDTH = 8;
  localparam int SHIFT     = 7;
  localparam int DEPTH     = 4;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 ovf_clr = 1'b0;
  logic [ACC_WIDTH-1:0] resulta = '0;
  logic [ACC_WIDTH-1:0] resultb = '0;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid, out_last, overflow, sat_seen;
  logic [LW-1:0]        level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_result_drain #(
    .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .resulta(resulta), .resultb(resultb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .ovf_clr(ovf_clr), .overflow(overflow), .sat_seen(sat_seen), .level(level)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: integer floor-division rounding and a queue of pairs.
  typedef struct {
    int a;
    int b;
  } pair_t;

  pair_t mq[$];
  pair_t m_pair;
  bit    m_selb, m_pend, m_pend_sat, m_ovf, m_sat;
  bit    m_full, m_hs, m_pop, m_sa, m_sb, m_ovf_ev, m_sat_ev;

  function automatic int quant(input int x, output bit sat);
    int r, s, hi, lo;
    r  = x + (1 << (SHIFT - 1));
    if (r >= 0) s = r / (1 << SHIFT);
    else        s = -((-r + (1 << SHIFT) - 1) / (1 << SHIFT));
    hi  = (1 << (OUT_WIDTH - 1)) - 1;
    lo  = -(1 << (OUT_WIDTH - 1));
    sat = (s > hi) || (s < lo);
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_selb = 0; m_pend = 0; m_pend_sat = 0; m_ovf = 0; m_sat = 0;
    end else begin
      m_full   = (mq.size() == DEPTH);
      m_hs     = (mq.size() != 0) && out_ready;
      m_pop    = m_hs && m_selb;
      m_ovf_ev = 0;
      m_sat_ev = 0;
      if (m_hs) begin
        if (m_selb) begin
          void'(mq.pop_front());
          m_selb = 0;
        end else begin
          m_selb = 1;
        end
      end
      if (m_pend) begin
        if (!m_full || m_pop) mq.push_back(m_pair);
        else m_ovf_ev = 1;
        m_sat_ev = m_pend_sat;
      end
      m_ovf  = m_ovf_ev || (m_ovf && !ovf_clr);
      m_sat  = m_sat_ev || (m_sat && !ovf_clr);
      m_pend = in_valid;
      if (in_valid) begin
        m_pair.a   = quant(int'($signed(resulta)), m_sa);
        m_pair.b   = quant(int'($signed(resultb)), m_sb);
        m_pend_sat = m_sa || m_sb;
      end
    end
  end

  // Per-cycle compare on the falling edge, plus stall stability.
  logic [OUT_WIDTH-1:0] exp_data, prev_data;
  logic                 exp_valid, prev_stall, prev_last;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      exp_valid = (mq.size() != 0);
      exp_data  = '0;
      if (exp_valid) exp_data = m_selb ? OUT_WIDTH'(mq[0].b) : OUT_WIDTH'(mq[0].a);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("out_data",  32'(out_data),  32'(exp_data));
      check("out_last",  32'(out_last),  32'(exp_valid && m_selb));
      check("level",     32'(level),     32'(mq.size()));
      check("overflow",  32'(overflow),  32'(m_ovf));
      check("sat_seen",  32'(sat_seen),  32'(m_sat));
      if (prev_stall) begin
        check("stall_data",  32'(out_data),  32'(prev_data));
        check("stall_last",  32'(out_last),  32'(prev_last));
        check("stall_valid", 32'(out_valid), 32'd1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Log of accepted words as {last, data}.
  logic [OUT_WIDTH:0] got[$];
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) got.push_back({out_last, out_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int b);
    resulta  = ACC_WIDTH'(a);
    resultb  = ACC_WIDTH'(b);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (level != 0 || m_pend); i++) step();
    step();
    check({name, "_drained"}, 32'(level), 32'd0);
  endtask

  task automatic check_word(input string name, input int idx, input logic [OUT_WIDTH:0] exp);
    logic [OUT_WIDTH:0] g;
    g = (idx < got.size()) ? got[idx] : 'x;
    check(name, 32'(g), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_sat_seen",  32'(sat_seen),  32'd0);
    step();
    reset = 1'b0;
    step();

    // Basic pair and latency
    out_ready = 1'b1;
    got.delete();
    push(1280, -1280);
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      step();
      cnt++;
    end
    check("basic_latency", 32'(cnt), 32'd2);
    drain("basic");
    check_word("basic_w0", 0, 9'h00A);
    check_word("basic_w1", 1, 9'h1F6);

    // Rounding
    got.delete();
    push(192, -192);
    push(63, 64);
    drain("round");
    check_word("round_w0", 0, 9'h002);
    check_word("round_w1", 1, 9'h1FF);
    check_word("round_w2", 2, 9'h000);
    check_word("round_w3", 3, 9'h101);
    check("round_sat_seen", 32'(sat_seen), 32'd0);

    // Saturation and sticky clear
    got.delete();
    push(20000, -20000);
    drain("sat");
    check_word("sat_w0", 0, 9'h07F);
    check_word("sat_w1", 1, 9'h180);
    check("sat_seen_set", 32'(sat_seen), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("sat_seen_clr", 32'(sat_seen), 32'd0);

    // Full / overflow: pair 5 dropped
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(128 * k, -128 * k);
    step();
    step();
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_flag",  32'(overflow), 32'd1);
    got.delete();
    drain("ovf");
    check("ovf_count", 32'(got.size()), 32'd8);
    for (int k = 1; k <= 4; k++) begin
      check_word("ovf_wa", 2 * k - 2, {1'b0, OUT_WIDTH'(k)});
      check_word("ovf_wb", 2 * k - 1, {1'b1, OUT_WIDTH'(-k)});
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full with a pair completing on the same edge as the push
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) push(128 * k, -128 * k);
    step();
    step();
    got.delete();
    out_ready = 1'b1;
    push(768, -768);
    step();
    out_ready = 1'b0;
    check("fullpop_level",    32'(level),    32'd4);
    check("fullpop_overflow", 32'(overflow), 32'd0);
    drain("fullpop");
    check("fullpop_count", 32'(got.size()), 32'd10);
    check_word("fullpop_w8", 8, 9'h006);
    check_word("fullpop_w9", 9, 9'h1FA);

    // Random backpressure
    for (int i = 0; i < 80; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (i < 40) && ($urandom_range(0, 2) == 0);
      resulta   = ACC_WIDTH'(int'($urandom_range(0, 40000)) - 20000);
      resultb   = ACC_WIDTH'(int'($urandom_range(0, 40000)) - 20000);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    drain("random");

    // Asynchronous reset with level 3 in SEL_B
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) push(128 * k, -128 * k);
    step();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pre_rst_level", 32'(level), 32'd3);
    check("pre_rst_last",  32'(out_last), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_last",  32'(out_last),  32'd0);
    check("async_rst_level", 32'(level),     32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    got.delete();
    out_ready = 1'b1;
    push(1280, -1280);
    drain("post_rst");
    check_word("post_rst_w0", 0, 9'h00A);
    check_word("post_rst_w1", 1, 9'h1F6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
